// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : dmem_arbiter_if                                                |
// | Two-requester data-memory bus plus the shared memory port.                 |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  m0_req;
  logic                  m0_we;
  logic [ADDR_WIDTH+1:0] m0_addr;
  logic [1:0]            m0_size;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_gnt;
  logic                  m0_rvalid;
  logic                  m0_err;

  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_WIDTH+1:0] m1_addr;
  logic [1:0]            m1_size;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_gnt;
  logic                  m1_rvalid;
  logic                  m1_err;

  logic [DATA_WIDTH-1:0] rdata;

  logic [ADDR_WIDTH-1:0] mem_A;
  logic [DATA_WIDTH-1:0] mem_inD;
  logic [3:0]            mem_sel;
  logic                  mem_str;
  logic [DATA_WIDTH-1:0] mem_outD;

  // Arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_size, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_size, m1_wdata,
    output m0_gnt, m0_rvalid, m0_err,
    output m1_gnt, m1_rvalid, m1_err,
    output rdata,
    output mem_A, mem_inD, mem_sel, mem_str,
    input  mem_outD
  );

  // Requester / memory side
  modport master (
    output m0_req, m0_we, m0_addr, m0_size, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_size, m1_wdata,
    input  m0_gnt, m0_rvalid, m0_err,
    input  m1_gnt, m1_rvalid, m1_err,
    input  rdata,
    input  mem_A, mem_inD, mem_sel, mem_str,
    output mem_outD
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_arbiter                                                    |
// | Two-requester arbiter for a shared byte-lane data memory (3-cycle access). |
// | Macro    : DMEM_ARB_RR_EN selects round-robin, otherwise fixed priority.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]            r_state;
  logic                  r_owner;
  logic                  r_we;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [1:0]            r_size;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_any_req;
  logic                  w_winner;
  logic                  w_in_access;
  logic                  w_in_resp;
  logic [1:0]            w_off;
  logic                  w_legal;
  logic [3:0]            w_lanes;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] w_load;

  assign w_any_req = bus.m0_req | bus.m1_req;

`ifdef DMEM_ARB_RR_EN
  // r_prio names the requester that wins the next tie
  logic r_prio;

  assign w_winner = (bus.m0_req && bus.m1_req) ? r_prio : ~bus.m0_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_prio <= ~w_winner;
    end
  end
`else
  assign w_winner = ~bus.m0_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_size  <= 2'b00;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_winner;
            r_we    <= w_winner ? bus.m1_we    : bus.m0_we;
            r_addr  <= w_winner ? bus.m1_addr  : bus.m0_addr;
            r_size  <= w_winner ? bus.m1_size  : bus.m0_size;
            r_wdata <= w_winner ? bus.m1_wdata : bus.m0_wdata;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: r_state <= S_RESP;
        S_RESP:   r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign w_in_access = (r_state == S_ACCESS);
  assign w_in_resp   = (r_state == S_RESP);
  assign w_off       = r_addr[1:0];

  always_comb begin
    w_legal = 1'b0;
    w_lanes = 4'b0000;
    case (r_size)
      2'b00: begin
        w_legal = 1'b1;
        w_lanes = 4'b0001 << w_off;
      end
      2'b01: begin
        w_legal = ~w_off[0];
        w_lanes = w_off[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        w_legal = (w_off == 2'b00);
        w_lanes = 4'b1111;
      end
      default: begin
        w_legal = 1'b0;
        w_lanes = 4'b0000;
      end
    endcase
  end

  // Gating with rst_n keeps a store that is being reset from reaching memory
  assign bus.mem_sel = (w_in_access && w_legal && rst_n) ? w_lanes : 4'b0000;
  assign bus.mem_str = w_in_access && w_legal && r_we && rst_n;
  assign bus.mem_A   = r_addr[ADDR_WIDTH+1:2];
  assign bus.mem_inD = r_wdata << {w_off, 3'b000};

  // Loads come back right-justified and zero-extended
  assign w_shifted = bus.mem_outD >> {w_off, 3'b000};

  always_comb begin
    w_load = '0;
    case (r_size)
      2'b00:   w_load[7:0]  = w_shifted[7:0];
      2'b01:   w_load[15:0] = w_shifted[15:0];
      default: w_load       = w_shifted;
    endcase
  end

  assign bus.rdata = (w_in_resp && w_legal && !r_we && rst_n) ? w_load : '0;

  assign bus.m0_gnt    = w_in_access & ~r_owner;
  assign bus.m1_gnt    = w_in_access &  r_owner;
  assign bus.m0_rvalid = w_in_resp & ~r_owner & rst_n;
  assign bus.m1_rvalid = w_in_resp &  r_owner & rst_n;
  assign bus.m0_err    = w_in_resp & ~r_owner & ~w_legal & rst_n;
  assign bus.m1_err    = w_in_resp &  r_owner & ~w_legal & rst_n;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dmem_arbiter                                                 |
// | Directed bench for dmem_arbiter with a behavioural byte-lane memory.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus ();

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Registered-read memory: data appears the cycle after mem_sel
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (bus.mem_sel != 4'b0000) begin
      bus.mem_outD <= mem[bus.mem_A];
      if (bus.mem_str) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_sel[b]) mem[bus.mem_A][8*b +: 8] <= bus.mem_inD[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic m, input logic we, input logic [11:0] addr,
                       input logic [1:0] size, input logic [31:0] wdata);
    if (!m) begin
      bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr;
      bus.m0_size = size; bus.m0_wdata = wdata;
    end else begin
      bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr;
      bus.m1_size = size; bus.m1_wdata = wdata;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic txn(input string tag, input logic m, input logic we,
                     input logic [11:0] addr, input logic [1:0] size,
                     input logic [31:0] wdata, input logic [3:0] esel,
                     input logic [31:0] eind, input logic eerr,
                     input logic [31:0] erd);
    drive(m, we, addr, size, wdata);
    step();
    chk({tag, ".gnt"},  {bus.m1_gnt, bus.m0_gnt}, m ? 32'd2 : 32'd1);
    chk({tag, ".sel"},  bus.mem_sel, esel);
    chk({tag, ".str"},  bus.mem_str, we & (esel != 4'b0000));
    chk({tag, ".A"},    bus.mem_A, addr[11:2]);
    chk({tag, ".inD"},  bus.mem_inD, eind);
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    step();
    chk({tag, ".rvalid"}, {bus.m1_rvalid, bus.m0_rvalid}, m ? 32'd2 : 32'd1);
    chk({tag, ".err"},    m ? bus.m1_err : bus.m0_err, eerr);
    chk({tag, ".rdata"},  bus.rdata, erd);
    chk({tag, ".gnt_resp"}, {bus.m1_gnt, bus.m0_gnt}, 32'd0);
    step();
    chk({tag, ".rvalid_end"}, {bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".gnt"},    {bus.m1_gnt, bus.m0_gnt}, 32'd0);
    chk({tag, ".rvalid"}, {bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
    chk({tag, ".err"},    {bus.m1_err, bus.m0_err}, 32'd0);
    chk({tag, ".sel"},    bus.mem_sel, 32'd0);
    chk({tag, ".str"},    bus.mem_str, 32'd0);
    chk({tag, ".A"},      bus.mem_A, 32'd0);
    chk({tag, ".inD"},    bus.mem_inD, 32'd0);
    chk({tag, ".rdata"},  bus.rdata, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_size = 2'b00; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_size = 2'b00; bus.m1_wdata = '0;

    rst_n = 1'b0;
    step();
    step();
    check_reset_state("reset");
    rst_n = 1'b1;

    txn("st_w",     1'b0, 1'b1, 12'h010, 2'b10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0);
    txn("ld_w",     1'b0, 1'b0, 12'h010, 2'b10, 32'h0,        4'b1111, 32'h0,        1'b0, 32'hDEADBEEF);
    txn("st_b",     1'b1, 1'b1, 12'h013, 2'b00, 32'h000000AB, 4'b1000, 32'hAB000000, 1'b0, 32'h0);
    txn("ld_b",     1'b1, 1'b0, 12'h013, 2'b00, 32'h0,        4'b1000, 32'h0,        1'b0, 32'h000000AB);
    txn("ld_h_mis", 1'b0, 1'b0, 12'h001, 2'b01, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0);
    txn("st_ill",   1'b1, 1'b1, 12'h021, 2'b11, 32'h00000055, 4'b0000, 32'h00005500, 1'b1, 32'h0);
    txn("st_h",     1'b0, 1'b1, 12'h012, 2'b01, 32'h0000BEEF, 4'b1100, 32'hBEEF0000, 1'b0, 32'h0);
    txn("ld_h",     1'b1, 1'b0, 12'h012, 2'b01, 32'h0,        4'b1100, 32'h0,        1'b0, 32'h0000BEEF);
    txn("ld_w_mis", 1'b0, 1'b0, 12'h012, 2'b10, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0);
    txn("ld_b0",    1'b0, 1'b0, 12'h010, 2'b00, 32'h0,        4'b0001, 32'h0,        1'b0, 32'h000000EF);

    // Reset restores the pointer so the tie sequence starts with m0
    rst_n = 1'b0;
    step();
    check_reset_state("reset2");
    rst_n = 1'b1;

    drive(1'b0, 1'b0, 12'h010, 2'b10, 32'h0);
    drive(1'b1, 1'b0, 12'h010, 2'b10, 32'h0);
    for (int k = 0; k < 4; k++) begin
      logic exp_m1;
      exp_m1 = RR ? k[0] : 1'b0;
      step();
      chk($sformatf("arb%0d.gnt", k), {bus.m1_gnt, bus.m0_gnt}, exp_m1 ? 32'd2 : 32'd1);
      step();
      chk($sformatf("arb%0d.rvalid", k), {bus.m1_rvalid, bus.m0_rvalid}, exp_m1 ? 32'd2 : 32'd1);
      chk($sformatf("arb%0d.rdata", k), bus.rdata, 32'hBEEFBEEF);
      step();
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;

    txn("st_prior", 1'b0, 1'b1, 12'h020, 2'b10, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0);

    drive(1'b0, 1'b1, 12'h020, 2'b10, 32'h11223344);
    step();
    chk("abort.gnt", bus.m0_gnt, 32'd1);
    chk("abort.str_before", bus.mem_str, 32'd1);
    rst_n = 1'b0;
    bus.m0_req = 1'b0;
    #1;
    chk("abort.str_in_reset", bus.mem_str, 32'd0);
    step();
    chk("abort.rvalid", {bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("abort.rvalid_after", {bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
    chk("abort.gnt_after", {bus.m1_gnt, bus.m0_gnt}, 32'd0);

    txn("ld_after", 1'b0, 1'b0, 12'h020, 2'b10, 32'h0, 4'b1111, 32'h0, 1'b0, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL be the word width of the shared data memory.
REQ-002 Parameter ADDR_WIDTH, default 10, SHALL be the memory word-address width; requester byte addresses are ADDR_WIDTH+2 bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 m0_req, m1_req  input  1  SHALL be requester 0/1 access requests, held high until the matching gnt.
REQ-006 m0_we, m1_we  input  1  SHALL select store (1) or load (0).
REQ-007 m0_addr, m1_addr  input  ADDR_WIDTH+2  SHALL be byte addresses.
REQ-008 m0_size, m1_size  input  2  SHALL select 00 byte, 01 half, 10 word; 11 is illegal.
REQ-009 m0_wdata, m1_wdata  input  DATA_WIDTH  SHALL be right-justified store data.
REQ-010 m0_gnt, m1_gnt  output  1  SHALL pulse for one cycle when that requester's access is issued.
REQ-011 m0_rvalid, m1_rvalid  output  1  SHALL pulse for one cycle when that access completes.
REQ-012 m0_err, m1_err  output  1  SHALL pulse with rvalid when the access was illegal.
REQ-013 rdata  output  DATA_WIDTH  SHALL be load data, shared by both requesters and qualified by mX_rvalid.
REQ-014 mem_A  output  ADDR_WIDTH, mem_inD  output  DATA_WIDTH, mem_sel  output  4, mem_str  output  1  SHALL drive the memory word address, write data, byte lanes and store strobe.
REQ-015 mem_outD  input  DATA_WIDTH  SHALL be the registered memory read data, valid one cycle after mem_sel is presented.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS and RESP; each transaction SHALL take exactly 3 cycles (IDLE, ACCESS, RESP), and no second grant SHALL occur before RESP ends.
REQ-017 IDLE with any req: latch the winner's we/addr/size/wdata and go to ACCESS; with no req: stay in IDLE.
REQ-018 In ACCESS: assert the winner's gnt, drive mem_A=addr[ADDR_WIDTH+1:2] and mem_sel from the lane map, and drive mem_str=we; go to RESP.
REQ-019 Lane map (little-endian): byte at offset k -> sel bit k (0001/0010/0100/1000); half at offset 0 -> 0011; half at offset 2 -> 1100; word -> 1111.
REQ-020 Store data SHALL be shifted to its lane: mem_inD = wdata << (8*addr[1:0]).
REQ-021 In RESP: assert the winner's rvalid; rdata=mem_outD for legal loads, otherwise 0; return to IDLE.
REQ-022 Illegal accesses (size 11, half with addr[0]=1, word with addr[1:0]!=00) SHALL still be granted, SHALL keep mem_sel=0000 and mem_str=0 in ACCESS, and SHALL assert err with rvalid in RESP.
REQ-023 Outside ACCESS, mem_sel SHALL be 0000 and mem_str 0; mem_A and mem_inD hold the last latched values.
REQ-024 req inputs SHALL be ignored in ACCESS and RESP; a req still high in the IDLE following RESP starts a new transaction.
REQ-025 When both requesters are requesting in IDLE, arbitration SHALL follow REQ-029/REQ-030.

Reset
REQ-026 With rst_n low at a posedge: state=IDLE; all gnt/rvalid/err=0; mem_str=0; mem_sel=0000; mem_A, mem_inD and rdata=0; round-robin pointer favours requester 0.
REQ-027 Reset mid-transaction SHALL abort it with no rvalid; a store aborted in ACCESS before the edge SHALL NOT be written.

Configuration
REQ-028 The macro DMEM_ARB_RR_EN SHALL select the arbitration policy.
REQ-029 DMEM_ARB_RR_EN defined: round-robin; on a tie, grant the requester not granted last; the pointer updates on each grant.
REQ-030 DMEM_ARB_RR_EN undefined: fixed priority; requester 0 always wins a tie and no pointer register exists.

Verification
REQ-031 m0 store word 0xDEADBEEF @0x010, then m0 load word @0x010 -> mem_sel=1111, mem_str=1 once; load rdata=0xDEADBEEF with m0_rvalid in cycle 3.
REQ-032 m1 store byte 0xAB @0x013, then load byte @0x013 -> mem_sel=1000, mem_inD=0xAB000000; rdata=0x000000AB.
REQ-033 m0 load half @0x001 -> m0_gnt, mem_sel=0000, mem_str=0, m0_err=1 with m0_rvalid, rdata=0.
REQ-034 Both req held for 4 transactions: RR build -> grants m0,m1,m0,m1; fixed build -> m0,m0,m0,m0.
REQ-035 rst_n low during ACCESS of a store 0x11223344 @0x020, then load @0x020 -> no rvalid for the store; load returns the prior content.
